// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback select.
// Holds one instruction between the memory stage and the register file.
// It drives the register-file write port and a forwarding tap to execute.
// A held instruction writes only once, however long the stall lasts.
// Optional feature macro: WB_RETIRE_CNT_EN.
//   Defined:   saturating retired-instruction counter on retire_count.
//   Undefined: retire_count is tied to 0.
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [ADDR_W-1:0] destAddM,
    input  logic [DATA_W-1:0] alu_resultM,
    input  logic [DATA_W-1:0] MemReadDataM,
    input  logic              stallW,
    input  logic              flushW,
    output logic              RegWriteW,
    output logic [ADDR_W-1:0] destAddW,
    output logic [DATA_W-1:0] resultW,
    output logic              validW,
    output logic              fwdValidW,
    output logic [CNT_W-1:0]  retire_count
);

    logic              valid_q,   valid_d;
    logic              wb_en_q,   wb_en_d;
    logic [ADDR_W-1:0] dest_q,    dest_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              written_q, written_d;
    logic [DATA_W-1:0] wb_data;

    // Select the writeback source before the register so W sees a single value
    always_comb begin
        wb_data = MemtoRegM ? MemReadDataM : alu_resultM;
    end

    // Next state: flush beats stall; stall holds and marks the write as issued
    always_comb begin
        valid_d   = valid_q;
        wb_en_d   = wb_en_q;
        dest_d    = dest_q;
        result_d  = result_q;
        written_d = written_q;
        if (flushW) begin
            valid_d   = 1'b0;
            wb_en_d   = 1'b0;
            written_d = 1'b0;
        end else if (stallW) begin
            written_d = wb_en_q;
        end else begin
            valid_d   = validM;
            // R0 is hard-wired zero, so a write to it is suppressed here
            wb_en_d   = validM & RegWriteM & (destAddM != '0);
            dest_d    = destAddM;
            result_d  = wb_data;
            written_d = 1'b0;
        end
    end

    // MEM/WB register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            dest_q    <= '0;
            result_q  <= '0;
            written_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            wb_en_q   <= wb_en_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            written_q <= written_d;
        end
    end

    // Output decode; the forwarding tap ignores written_q so it stays up across a stall
    always_comb begin
        validW    = valid_q;
        destAddW  = dest_q;
        resultW   = result_q;
        RegWriteW = wb_en_q & ~written_q;
        fwdValidW = valid_q & wb_en_q;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // A slot retires when it leaves W normally; a killed slot does not count
    always_comb begin
        retire = valid_q & ~stallW & ~flushW;
        cnt_d  = cnt_q;
        if (retire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Saturating retire counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_count = cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a scoreboard queue of expected W outputs.
module tb_writeback_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, validM, RegWriteM, MemtoRegM, stallW, flushW;
    logic [AW-1:0] destAddM;
    logic [DW-1:0] alu_resultM, MemReadDataM;
    logic          RegWriteW, validW, fwdValidW;
    logic [AW-1:0] destAddW;
    logic [DW-1:0] resultW;
    logic [CW-1:0] retire_count;

    typedef struct {
        logic          rw;
        logic [AW-1:0] dest;
        logic [DW-1:0] res;
        logic          v;
        logic          fv;
        bit            chk_data;
        bit            chk_cnt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .validM(validM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .destAddM(destAddM), .alu_resultM(alu_resultM),
        .MemReadDataM(MemReadDataM), .stallW(stallW), .flushW(flushW),
        .RegWriteW(RegWriteW), .destAddW(destAddW), .resultW(resultW),
        .validW(validW), .fwdValidW(fwdValidW), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL step %0d %s: observed %h expected %h", step_no, tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic rw, input logic m2r,
                         input logic [AW-1:0] d, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mem, input logic st, input logic fl);
        reset = rst; validM = v; RegWriteM = rw; MemtoRegM = m2r; destAddM = d;
        alu_resultM = alu; MemReadDataM = mem; stallW = st; flushW = fl;
    endtask

    task automatic push(input logic rw, input logic [AW-1:0] d, input logic [DW-1:0] r,
                        input logic v, input logic fv, input bit cd,
                        input bit cc, input logic [CW-1:0] c);
        exp_t e;
        e.rw = rw; e.dest = d; e.res = r; e.v = v; e.fv = fv;
        e.chk_data = cd; e.chk_cnt = cc; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then pop the oldest expectation and compare against W outputs
    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL step %0d scoreboard_empty: observed 0 entries expected 1", step_no);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("RegWriteW", DW'(RegWriteW), DW'(e.rw));
            cmp("validW",    DW'(validW),    DW'(e.v));
            cmp("fwdValidW", DW'(fwdValidW), DW'(e.fv));
            if (e.chk_data) begin
                cmp("destAddW", DW'(destAddW), DW'(e.dest));
                cmp("resultW",  resultW,       e.res);
            end
            if (e.chk_cnt) cmp("retire_count", DW'(retire_count), DW'(e.cnt));
            $display("step %0d: rw=%b v=%b fv=%b dest=%0d res=%h cnt=%0d",
                     step_no, RegWriteW, validW, fwdValidW, destAddW, resultW, retire_count);
        end
    endtask

    logic [CW-1:0] cnt_mid, cnt_sat;

    initial begin
`ifdef WB_RETIRE_CNT_EN
        cnt_mid = 4'd9;
        cnt_sat = 4'hF;
`else
        cnt_mid = 4'd0;
        cnt_sat = 4'd0;
`endif
        // Reset: every output reads 0
        drive(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
        push(0, 0, 16'h0, 0, 0, 1, 1, 0); tick_check();
        push(0, 0, 16'h0, 0, 0, 1, 1, 0); tick_check();

        // 1. Load writeback selects memory data
        drive(0, 1, 1, 1, 4'd5, 16'h0010, 16'hBEEF, 0, 0);
        push(1, 4'd5, 16'hBEEF, 1, 1, 1, 0, 0); tick_check();

        // 2. ALU writeback, then R0 guard
        drive(0, 1, 1, 0, 4'd3, 16'h1234, 16'hBEEF, 0, 0);
        push(1, 4'd3, 16'h1234, 1, 1, 1, 0, 0); tick_check();
        drive(0, 1, 1, 0, 4'd0, 16'h1234, 16'hBEEF, 0, 0);
        push(0, 4'd0, 16'h1234, 1, 0, 1, 0, 0); tick_check();

        // 3. Capture dest 7, then stall three cycles with different M inputs
        drive(0, 1, 1, 0, 4'd7, 16'h0777, 16'h5555, 0, 0);
        push(1, 4'd7, 16'h0777, 1, 1, 1, 0, 0); tick_check();
        drive(0, 1, 1, 1, 4'd9, 16'h9999, 16'hAAAA, 1, 0);
        for (int i = 0; i < 3; i++) begin
            push(0, 4'd7, 16'h0777, 1, 1, 1, 0, 0); tick_check();
        end

        // 4. Flush with stall on the held instruction
        drive(0, 1, 1, 1, 4'd9, 16'h9999, 16'hAAAA, 1, 1);
        push(0, 0, 16'h0, 0, 0, 0, 0, 0); tick_check();
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0);
        push(0, 0, 16'h0, 0, 0, 0, 0, 0); tick_check();

        // 5. Reset mid-stall, then idle: no late write of the held instruction
        drive(0, 1, 1, 0, 4'd4, 16'hAAAA, 16'h0, 0, 0);
        push(1, 4'd4, 16'hAAAA, 1, 1, 1, 0, 0); tick_check();
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 1, 0);
        push(0, 4'd4, 16'hAAAA, 1, 1, 1, 0, 0); tick_check();
        drive(1, 0, 0, 0, 4'd0, 16'h0, 16'h0, 1, 0);
        push(0, 0, 16'h0, 0, 0, 1, 1, 0); tick_check();
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0);
        push(0, 0, 16'h0, 0, 0, 1, 1, 0); tick_check();
        push(0, 0, 16'h0, 0, 0, 1, 1, 0); tick_check();

        // 6. Twenty back-to-back instructions; counter saturates when enabled
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 1, 0, AW'(i % 15 + 1), DW'(i * 16'h0101), 16'h0, 0, 0);
            push(1, AW'(i % 15 + 1), DW'(i * 16'h0101), 1, 1, 1, (i == 10), cnt_mid);
            tick_check();
        end
        drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0);
        push(0, 4'd0, 16'h0, 0, 0, 0, 1, cnt_sat); tick_check();
        push(0, 4'd0, 16'h0, 0, 0, 0, 1, cnt_sat); tick_check();

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
